// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep valid/ready register chain with global stall and per-stage flush.
// Define PIPE_STAGE_CHAIN_PERF_EN to add the stall_cnt/kill_cnt performance counters.
module pipe_stage_chain #(
    parameter int                DATA_W = 64,
    parameter int                STAGES = 2,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(64'h0000_0000_0000_0013)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             stall,
    input  logic [STAGES-1:0]                flush_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [STAGES-1:0]                stage_valid,
    output logic [$clog2(STAGES+1)-1:0]      occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    output logic [31:0]                      stall_cnt,
    output logic [31:0]                      kill_cnt
`endif
);
    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0][DATA_W-1:0] r_data;
    logic [STAGES-1:0]             w_acc;
    logic [STAGES-1:0]             w_live;
    logic [STAGES:0]               w_src_v;
    logic [STAGES:0][DATA_W-1:0]   w_src_d;
    logic [OCC_W-1:0]              w_occ;

    // A flushed stage's payload must not propagate downstream either.
    assign w_live  = r_valid & ~flush_mask;
    assign w_src_v = {w_live, in_valid};
    assign w_src_d = {r_data, in_data};

    // Stage i accepts when unstalled and some stage at or after i is empty, or the sink drains.
    for (genvar i = 0; i < STAGES; i++) begin : g_acc
        assign w_acc[i] = !stall && (out_ready || (((~r_valid) >> i) != '0));
    end

    assign in_ready    = w_acc[0];
    assign out_valid   = r_valid[STAGES-1];
    assign out_data    = r_data[STAGES-1];
    assign stage_valid = r_valid;
    assign occupancy   = w_occ;

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) w_occ = w_occ + OCC_W'(r_valid[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= {STAGES{BUBBLE}};
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush_mask[i]) begin
                    r_valid[i] <= 1'b0;
                    r_data[i]  <= BUBBLE;
                end else if (w_acc[i]) begin
                    r_valid[i] <= w_src_v[i];
                    if (w_src_v[i]) r_data[i] <= w_src_d[i];
                end
            end
        end
    end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] w_kills;

    always_comb begin
        w_kills = '0;
        for (int i = 0; i < STAGES; i++) w_kills = w_kills + 32'(r_valid[i] & flush_mask[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(stall);
            kill_cnt  <= kill_cnt + w_kills;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter DATA_W, default 64, payload width per stage (instruction + PC).
REQ-002 Parameter STAGES, default 2, number of register stages, legal range 1..8.
REQ-003 Parameter BUBBLE, default 64'h0000_0000_0000_0013, payload loaded into a killed stage (NOP in low word).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream payload present.
REQ-007 in_ready  output  1  chain accepts in_data this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 stall  input  1  global freeze of all stages.
REQ-010 flush_mask  input  STAGES  bit i kills stage i contents at next edge; bit 0 is the youngest stage.
REQ-011 out_valid  output  1  oldest stage holds valid payload.
REQ-012 out_ready  input  1  downstream consumes oldest payload.
REQ-013 out_data  output  DATA_W  oldest stage payload.
REQ-014 stage_valid  output  STAGES  per-stage valid bits, for hazard logic.
REQ-015 occupancy  output  $clog2(STAGES+1)  count of valid stages.

Function
REQ-016 Stage i SHALL hold {valid[i], data[i]}; stage STAGES-1 drives out_valid/out_data.
REQ-017 Stage STAGES-1 SHALL advance when out_ready && !stall; stage i<STAGES-1 SHALL advance when stage i+1 accepts.
REQ-018 Stage i SHALL accept when !stall && (!valid[i] || advance[i]); in_ready SHALL equal stage 0 accept, combinationally.
REQ-019 Transfer into stage 0 SHALL occur on in_valid && in_ready; an accepting stage with no incoming valid SHALL clear valid and keep its data.
REQ-020 Latency SHALL be exactly STAGES cycles from input handshake to out_valid with out_ready held high; throughput one payload per cycle.
REQ-021 With stall high: no stage changes, in_ready=0, out_valid/out_data held; out_ready ignored.
REQ-022 flush_mask[i] SHALL, at the next edge, force valid[i]=0 and data[i]=BUBBLE, overriding stall and any incoming transfer.
REQ-023 Payload leaving stage i-1 toward a flushed stage i SHALL be discarded; stage i-1 still counts as advanced.
REQ-024 When flush_mask[STAGES-1] is high, the oldest payload SHALL still complete a handshake that cycle if out_valid && out_ready.
REQ-025 occupancy SHALL equal the popcount of stage_valid, registered-state based (no lookahead).
REQ-026 Full chain (all valid) with out_ready low SHALL drive in_ready=0 and hold all payloads unchanged.

Reset
REQ-027 rst SHALL clear every valid bit and load BUBBLE into every data register on the next edge.
REQ-028 After reset: out_valid=0, out_data=BUBBLE, in_ready=1, stage_valid=0, occupancy=0.
REQ-029 rst SHALL override stall and flush_mask; in_valid during reset SHALL be ignored.

Configuration
REQ-030 Macro PIPE_STAGE_CHAIN_PERF_EN SHALL add outputs stall_cnt[31:0] and kill_cnt[31:0].
REQ-031 With macro: stall_cnt increments each cycle stall is high; kill_cnt increments by the number of valid stages killed by flush_mask; both wrap at 2^32 and reset to 0.
REQ-032 Without macro: ports and counters SHALL not exist; all other behaviour identical.

Verification (STAGES=2, DATA_W=64)
REQ-033 Reset, then in_valid=1 data=0xA, out_ready=1 -> out_valid=1, out_data=0xA exactly 2 cycles after acceptance.
REQ-034 Stream 0x1,0x2,0x3 back-to-back, out_ready=0 after 0x1 enters -> in_ready=0 once both stages full, occupancy=2, no payload lost or duplicated after out_ready=1.
REQ-035 Chain holds 0x5 (stage0) and 0x4 (stage1), flush_mask=2'b01 with out_ready=1 -> 0x4 delivered, next cycle stage_valid=2'b00, data[0]=BUBBLE.
REQ-036 Stall high 3 cycles with full chain and flush_mask=2'b10 in cycle 2 -> stage 1 becomes bubble despite stall; stage 0 unchanged; stall_cnt=3 and kill_cnt=1 when PERF enabled.
REQ-037 Assert rst mid-stream with stall=1 and flush_mask=2'b11 -> next cycle out_valid=0, occupancy=0, in_ready=1, counters=0.
REQ-038 Random in_valid/out_ready/stall for 10k cycles without flush -> output sequence equals input sequence, in order, scoreboard-checked.
